// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid_if                                           |
// | Description : One valid/ready stream carrying a control bundle and a data  |
// |               bundle. The producer uses modport master, the consumer uses  |
// |               modport slave.                                               |
// | Signals     : valid  producer offers a beat                                |
// |               ready  consumer accepts; beat moves when valid & ready       |
// |               ctrl   CTRL_W-bit control bundle                             |
// |               data   DATA_W-bit data bundle                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 6
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                              |
// | Description : Pipeline register between two CPU stages with valid/ready   |
// |               handshake, flush-to-bubble and an optional 2-entry skid      |
// |               buffer that registers the upstream ready.                    |
// | Build macro : PIPE_STAGE_SKID_EN - defined: 2-entry skid buffer, in_ready  |
// |               is a register output, occupancy reaches 2.                   |
// |               undefined: single register, in_ready combinational from      |
// |               out_ready, occupancy at most 1.                              |
// | Ports       : clk          clock, rising edge                              |
// |               rst          synchronous active-high reset                   |
// |               flush_i      discard all held entries                        |
// |               in_if        upstream stream (slave)                         |
// |               out_if       downstream stream (master); ctrl is zero while  |
// |                            invalid, data holds the last loaded value       |
// |               occupancy_o  number of valid entries held                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         flush_i,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [1:0]        occupancy_o
);

  // Encoding equals the number of held entries so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  // Ready comes straight from a flop: no path from out_ready to in_ready.
  assign w_in_ready = in_ready_q;
`else
  // Single register: it can take a beat when empty or when it empties this cycle.
  assign w_in_ready = (state_q == ST_EMPTY) | out_if.ready;
`endif

  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_push      = in_if.valid & w_in_ready;
  assign w_pop       = w_out_valid & out_if.ready;

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = w_out_valid;
  assign out_if.ctrl  = w_out_valid ? m_ctrl_q : '0;  // bubble is a NOP
  assign out_if.data  = m_data_q;
  assign occupancy_o  = 2'(state_q);

  // --------------------------------------------------------------------------
  // Next-state and storage-load logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (w_push) begin
          m_ctrl_d = in_if.ctrl;
          m_data_d = in_if.data;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
        if (w_push && w_pop) begin
          m_ctrl_d = in_if.ctrl;
          m_data_d = in_if.data;
        end else if (w_push) begin
          // Downstream stalled: park the new beat behind M.
          s_ctrl_d = in_if.ctrl;
          s_data_d = in_if.data;
          state_d  = ST_FULL;
        end else if (w_pop) begin
          state_d = ST_EMPTY;
        end
`else
        if (w_push) begin
          m_ctrl_d = in_if.ctrl;
          m_data_d = in_if.data;
        end else if (w_pop) begin
          state_d = ST_EMPTY;
        end
`endif
      end
`ifdef PIPE_STAGE_SKID_EN
      ST_FULL: begin
        if (w_pop) begin
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          state_d  = ST_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops everything: an accepted push is discarded and storage keeps
    // its last loaded contents, so out_data still shows the previous beat.
    if (flush_i) begin
      state_d  = ST_EMPTY;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
`endif
    end

`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != ST_FULL);
`endif
  end

  // --------------------------------------------------------------------------
  // State and storage registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_skid                                           |
// | Description : Self-checking bench for pipe_stage_skid. A reference model   |
// |               (a bounded FIFO queue) tracks accepted beats; the monitor    |
// |               compares status every cycle and payload on every pop.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 6;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in_bus ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out_bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_if       (in_bus),
    .out_if      (out_bus),
    .occupancy_o (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and monitor. The model is a FIFO of capacity CAP; it
  // holds what the stage should hold after the most recent rising edge.
  // --------------------------------------------------------------------------
  beat_t            model_q[$];
  logic [DATA_W-1:0] last_data;
  bit               model_ok = 0;

  always @(negedge clk) begin
    bit    exp_ir;
    bit    exp_ov;
    bit    do_pop;
    beat_t b;
    exp_ov = (model_q.size() > 0);
    if (CAP == 2) exp_ir = (model_q.size() < 2);
    else          exp_ir = (model_q.size() == 0) || (out_bus.ready === 1'b1);
    do_pop = exp_ov && (out_bus.ready === 1'b1);

    if (model_ok) begin
      check("occupancy", 64'(occupancy), 64'(model_q.size()));
      check("in_ready", 64'(in_bus.ready), 64'(exp_ir));
      check("out_valid", 64'(out_bus.valid), 64'(exp_ov));
      if (!exp_ov) begin
        check("bubble_ctrl", 64'(out_bus.ctrl), 64'd0);
        check("idle_data", out_bus.data, last_data);
      end
      if (do_pop) begin
        b = model_q.pop_front();
        check("pop_ctrl", 64'(out_bus.ctrl), 64'(b.ctrl));
        check("pop_data", out_bus.data, b.data);
        delivered++;
      end
    end

    // Advance the model to what the next rising edge should commit.
    if (rst) begin
      model_q.delete();
      last_data = '0;
      model_ok  = 1;
    end else if (model_ok) begin
      if (flush) begin
        model_q.delete();
      end else if (in_bus.valid && exp_ir) begin
        b.ctrl = in_bus.ctrl;
        b.data = in_bus.data;
        model_q.push_back(b);
      end
      if (model_q.size() > 0) last_data = model_q[0].data;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                     input logic ordy, input logic fl, input logic r);
    in_bus.valid  = v;
    in_bus.ctrl   = c;
    in_bus.data   = d;
    out_bus.ready = ordy;
    flush         = fl;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start_del;
    // Reset held two cycles while upstream offers an all-ones control bundle.
    cyc(1'b1, 6'h3F, 64'hDEAD, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 6'h3F, 64'hDEAD, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 64'h0,    1'b0, 1'b0, 1'b0);

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 6'(i), 64'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A then B while stalled, then C offered as ready returns.
    cyc(1'b1, 6'h0A, 64'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0B, 64'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0C, 64'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full (or holding, without skid) with a simultaneous push D.
    cyc(1'b1, 6'h0A, 64'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0B, 64'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0D, 64'hD, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush coinciding with a pop of A: A delivered once, nothing follows.
    cyc(1'b1, 6'h0A, 64'hA, 1'b0, 1'b0, 1'b0);
    start_del = delivered;
    cyc(1'b0, 6'h00, 64'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("flush_pop_delivered", 64'(delivered - start_del), 64'd1);

    // Randomized traffic including occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 9) < 7),
          6'($urandom),
          {$urandom, $urandom},
          1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 199) == 0));
    end

    // Drain.
    for (int i = 0; i < 4; i++) cyc(1'b0, 6'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("drained_occupancy", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised successor to the fixed-width stall-only pipeline registers between CPU stages. Carries one generic control bundle and one data bundle from stage N to stage N+1 under a valid/ready handshake. Flush inserts a bubble. An optional 2-entry skid buffer breaks the combinational ready path. The EX/MEM, IF/ID and MEM/WB boundaries instantiate it with stage-specific widths.

## Interface
- `DATA_W`, 64: width of data bundle (ALU result, store data, instr, pc, rd…).
- `CTRL_W`, 6: width of control bundle (MemRead, MemWrite, MemtoReg, RegWrite, Halt, PCSave…).
- `clk`  in  1  clock. Single clock domain; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `flush`  in  1  discard all held entries (branch mispredict / exception).
- `in_valid`  in  1  upstream offers a beat.
- `in_ready`  out  1  stage can accept; a beat transfers when `in_valid & in_ready`.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  beat available to downstream.
- `out_ready`  in  1  downstream accepts; a beat transfers when `out_valid & out_ready` (replaces old `~stall`).
- `out_ctrl`  out  CTRL_W  control bundle; forced to 0 whenever `out_valid`=0 (bubble is NOP).
- `out_data`  out  DATA_W  data bundle; holds last loaded value when invalid.
- `occupancy`  out  2  number of valid entries held (0..2; max 1 without skid).

## Operation
- Reset (rst=1 at edge): all entries invalid. `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1 the cycle after.
- Storage: main register M drives outputs; skid register S exists only with skid enabled.
- States (skid build): EMPTY (M invalid), ONE (M valid, S invalid), FULL (M, S valid).
  - EMPTY: push → M←in, ONE. Pop impossible.
  - ONE: push&pop → M←in, ONE. Push only → S←in, FULL. Pop only → EMPTY.
  - FULL: no push possible (`in_ready`=0). Pop → M←S, ONE.
- `in_ready` (skid build) = ~S_valid, a pure register output.
- Non-skid build: M only. `in_ready` = ~M_valid | out_ready (combinational). Push&pop → M←in. Push only → M←in. Pop only → invalid.
- Flush: next state EMPTY regardless of current state. A push in the same cycle is acknowledged per `in_ready` and then discarded. A pop in the same cycle completes normally; downstream keeps its beat. Priority: `rst` > `flush` > handshake.
- Order strictly FIFO; no beat duplicated or dropped except by flush/reset.
- ctrl and data of an entry always move together.

## Timing
- Latency: accepted beat appears on `out_*` the cycle after acceptance.
- Throughput: one beat/cycle sustained while `out_ready`=1.
- Skid build: `in_ready` deasserts the cycle after a push-without-pop from ONE. It reasserts the cycle after the first pop from FULL.
- After flush: `out_valid`=0, `out_ctrl`=0, `occupancy`=0 next cycle; `in_ready`=1 next cycle.
- Reset asserted mid-transfer behaves identically to flush plus zeroing `out_data`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: 2-entry skid buffer. `in_ready` is registered; there is no `out_ready`→`in_ready` combinational path. `occupancy` reaches 2.
- Not defined: single register with combinational `in_ready`. Same latency and throughput; `occupancy` never exceeds 1. S and its logic are absent.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1, `in_ctrl`=6'h3F → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0; `in_ready`=1 after release.
- Streaming: `out_ready`=1, push data 1,2,3,4 on consecutive cycles → out 1,2,3,4 on the next 4 cycles; `occupancy`=1 throughout.
- Backpressure (skid): `out_ready`=0, push A then B → `in_ready`=0 after B, `occupancy`=2. Raise `out_ready` → A then B out; `in_ready`=1 after the first pop.
- Backpressure (non-skid): `out_ready`=0 with M full → `in_ready`=0 in the same cycle. Raise `out_ready` with `in_valid`=1, data C → C replaces A in 1 cycle; A is popped.
- Flush from FULL with a simultaneous push D → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0; D never appears.
- Flush with a simultaneous pop of A (`out_ready`=1) → A counted as delivered once; no beat follows.
